// File: rtl/register_4bit_pkg.sv
// Shared constants for the parallel-load data register.
package register_4bit_pkg;

    localparam int unsigned REG_WIDTH_DEFAULT = 4;

endpackage : register_4bit_pkg

// File: rtl/register_bit.sv
// One storage bit: async active-low clear to a per-bit reset value, clock-enabled load.
module register_bit #(
    parameter logic RESET_VALUE = 1'b0
) (
    input  logic clk,
    input  logic clr_n,
    input  logic ce,
    input  logic d,
    output logic q
);

    logic q_q;
    logic q_d;

    // Hold unless enabled; clear is handled by the flop itself.
    always_comb begin
        q_d = q_q;
        if (ce) begin
            q_d = d;
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            q_q <= RESET_VALUE;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule : register_bit

// File: rtl/register_4bit.sv
// Clock-enabled parallel-load data register, WIDTH bits, async active-low clear.
module register_4bit
    import register_4bit_pkg::*;
#(
    parameter int unsigned          WIDTH       = REG_WIDTH_DEFAULT,
    parameter logic [WIDTH-1:0]     RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             ce,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Lanes are independent, so each bit is its own flop with its own reset value.
    for (genvar i = 0; i < int'(WIDTH); i++) begin : g_bit
        register_bit #(
            .RESET_VALUE (RESET_VALUE[i])
        ) u_bit (
            .clk   (clk),
            .clr_n (clr_n),
            .ce    (ce),
            .d     (d[i]),
            .q     (q[i])
        );
    end

`ifndef SYNTHESIS
    a_clear_value : assert property (@(posedge clk) !clr_n |-> (q == RESET_VALUE))
        else $error("q differs from RESET_VALUE while clear is asserted");

    a_hold_stable : assert property (@(posedge clk) disable iff (!clr_n) !ce |=> $stable(q))
        else $error("q changed across an edge with ce low");

    a_ce_known : assert property (@(posedge clk) disable iff (!clr_n) !$isunknown(ce))
        else $error("ce is X/Z while clear is released");
`endif

endmodule : register_4bit

// File: tb/tb_register_4bit.sv
// Directed bench for register_4bit: default 4-bit instance plus an 8-bit, 8'hA5-reset instance.
module tb_register_4bit;

    localparam logic [3:0] RV4 = 4'b0000;
    localparam logic [7:0] RV8 = 8'hA5;

    logic       clk;
    logic       clr_n;
    logic       ce;
    logic [3:0] d4;
    logic [7:0] d8;
    logic [3:0] q4;
    logic [7:0] q8;

    int nvec;
    int nerr;

    // Behavioural expectation: value the register must hold, plus validity after first clear.
    logic [3:0] m4;
    logic [7:0] m8;
    bit         model_ok;

    register_4bit u_dut4 (
        .clk   (clk),
        .clr_n (clr_n),
        .ce    (ce),
        .d     (d4),
        .q     (q4)
    );

    register_4bit #(
        .WIDTH       (8),
        .RESET_VALUE (RV8)
    ) u_dut8 (
        .clk   (clk),
        .clr_n (clr_n),
        .ce    (ce),
        .d     (d8),
        .q     (q8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void check(input string name, input logic [7:0] act, input logic [7:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h, expected %h at t=%0t", name, act, exp, $time);
        end
    endfunction

    // Model: clear wins instantly; at an edge, a released register takes d only when enabled.
    always @(negedge clr_n) begin
        m4 = RV4;
        m8 = RV8;
        model_ok = 1'b1;
    end

    always @(posedge clk) begin
        if (clr_n !== 1'b1) begin
            m4 = RV4;
            m8 = RV8;
        end else if (ce === 1'b1) begin
            m4 = d4;
            m8 = d8;
        end
    end

    // Compare process: every falling edge, once the register has been cleared.
    always @(negedge clk) begin
        if (model_ok) begin
            check("model_q4", {4'b0, q4}, {4'b0, m4});
            check("model_q8", q8, m8);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        nvec     = 0;
        nerr     = 0;
        model_ok = 1'b0;
        m4       = '0;
        m8       = '0;
        clr_n    = 1'b1;
        ce       = 1'b0;
        d4       = 4'b0000;
        d8       = 8'h00;

        // Initial clear
        #3 clr_n = 1'b0;
        #1;
        check("clear_now_q4", {4'b0, q4}, 8'h00);
        check("clear_now_q8", q8, 8'hA5);
        step();
        step();

        // 1: release with ce=0, d=1011 -> hold reset value
        #3;
        clr_n = 1'b1;
        d4    = 4'b1011;
        d8    = 8'h5A;
        step();
        step();
        check("t1_hold_q4", {4'b0, q4}, 8'h00);
        check("t1_hold_q8", q8, 8'hA5);

        // 2: loads with one edge latency
        ce = 1'b1;
        d4 = 4'b1000;
        d8 = 8'h3C;
        step();
        check("t2_load_1000", {4'b0, q4}, 8'h08);
        check("t2_load_3c", q8, 8'h3C);
        d4 = 4'b0001;
        d8 = 8'hC3;
        step();
        check("t2_load_0001", {4'b0, q4}, 8'h01);
        check("t2_load_c3", q8, 8'hC3);

        // 3: clear midway between edges with ce=1
        d4 = 4'b1110;
        d8 = 8'hFF;
        #3 clr_n = 1'b0;
        #1;
        check("t3_async_q4", {4'b0, q4}, 8'h00);
        check("t3_async_q8", q8, 8'hA5);
        step();
        step();
        check("t3_held_q4", {4'b0, q4}, 8'h00);
        check("t3_held_q8", q8, 8'hA5);

        // 4: release midway, ce=1, d=1111
        #3;
        d4    = 4'b1111;
        d8    = 8'h81;
        ce    = 1'b1;
        clr_n = 1'b1;
        #1;
        check("t4_release_q4", {4'b0, q4}, 8'h00);
        check("t4_release_q8", q8, 8'hA5);
        step();
        check("t4_load_q4", {4'b0, q4}, 8'h0F);
        check("t4_load_q8", q8, 8'h81);

        // 5: ce=0 while d toggles -> hold, then enable
        ce = 1'b0;
        for (int i = 0; i < 3; i++) begin
            d4 = (i % 2 == 0) ? 4'b0101 : 4'b1010;
            d8 = (i % 2 == 0) ? 8'h55 : 8'hAA;
            step();
            check("t5_hold_q4", {4'b0, q4}, 8'h0F);
            check("t5_hold_q8", q8, 8'h81);
        end
        ce = 1'b1;
        d4 = 4'b0011;
        d8 = 8'h12;
        step();
        check("t5_reload_q4", {4'b0, q4}, 8'h03);
        check("t5_reload_q8", q8, 8'h12);

        // 6: glitch d between edges -> only the value at the edge is taken
        d4 = 4'b0110;
        d8 = 8'h66;
        #2;
        d4 = 4'b1001;
        d8 = 8'h99;
        step();
        check("t6_glitch_q4", {4'b0, q4}, 8'h09);
        check("t6_glitch_q8", q8, 8'h99);

        // Final clear shows the per-bit reset values
        #3 clr_n = 1'b0;
        #1;
        check("final_clear_q4", {4'b0, q4}, 8'h00);
        check("final_clear_q8", q8, 8'hA5);
        step();
        @(negedge clk);
        #1;

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule : tb_register_4bit
